go_dispatch: RTL and testbench
==============================

Name: go_dispatch

Overview:
- Synthesizable launch controller for go2ir-generated method blocks.
- Optionally preloads the shared memory ports with a linear pattern (address + FILL_BASE).
- Then kicks N_CH methods through their req/busy handshakes, in parallel or strictly in index order.
- Reports completion and the elapsed cycle count. It sits beside a generated `goroutines` instance and replaces hand-written kick/fill logic.

Parameters:
N_CH, 3, number of method req/busy channels (1..16)
ADDR_W, 32, memory address width
DATA_W, 32, memory data width
DEPTH, 16, words written per fill (1..2^ADDR_W)
FILL_BASE, 1, value written at address 0; word k gets FILL_BASE+k
CNT_W, 32, cycle counter width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle request to begin a run
fill_en  in  1  sampled with start; 1 = run FILL phase
mode  in  1  sampled with start; 0 = parallel, 1 = sequential
en_mask  in  N_CH  sampled with start; channels to launch
m_req  out  N_CH  one-cycle kick per method
m_busy  in  N_CH  method busy flags
mem_address  out  ADDR_W  broadcast to all memory ports
mem_we  out  1  write enable
mem_oe  out  1  output enable
mem_din  out  DATA_W  write data
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
cycles  out  CNT_W  cycles from accepted start to done

Behaviour:
- Clock and reset: one clock, `clk`; `reset` is synchronous and active-high.
- Reset values:
  - m_req=0, mem_we=0, mem_oe=1, mem_address=0, mem_din=0.
  - busy=0, done=0, cycles=0, FSM=IDLE.
  - Reset asserted in any state aborts the run at the next edge. No done pulse is generated.
- States: IDLE, FILL, LAUNCH, WAIT, DONE.
- IDLE:
  - start=1 latches fill_en, mode and en_mask; clears cycles; sets busy=1.
  - Next state is FILL if fill_en=1, else LAUNCH.
  - start outside IDLE is ignored.
- FILL:
  - Occupies DEPTH cycles, k=0..DEPTH-1: mem_we=1, mem_oe=1, mem_address=k, mem_din=FILL_BASE+k (mod 2^DATA_W).
  - After word DEPTH-1: mem_we=0, mem_address=0, mem_din=0, then go to LAUNCH.
- LAUNCH:
  - Latched mask 0: go directly to DONE.
  - Parallel mode: m_req=mask for exactly one cycle, then WAIT.
  - Sequential mode: pulse m_req[i] for the lowest-index pending channel i, then WAIT.
- WAIT:
  - m_busy is ignored for the first 2 cycles after the req pulse (settling window).
  - From the 3rd cycle, a channel completes when its sampled m_busy=0.
  - Parallel mode: leave WAIT when all masked channels read busy=0 in the same cycle.
  - Sequential mode: on completion, clear the channel's pending bit. Return to LAUNCH if bits remain, else go to DONE.
  - Unmasked m_busy bits are don't-care.
- DONE:
  - done=1 for one cycle and busy=0 in that same cycle; next state IDLE.
  - cycles holds its value until the next accepted start.
- cycles:
  - Increments every cycle busy=1, starting the cycle after start is accepted.
  - Saturates at 2^CNT_W-1.
  - The value visible with the done pulse is final.
- m_req:
  - Never asserted outside LAUNCH.
  - Never held longer than one cycle.
  - Never reissued to a channel within the same run.

Test Plan:
- Parallel, no fill:
  - Stimulus: N_CH=3, mask=3'b111, mode=0, fill_en=0. Methods hold busy for 5, 9 and 2 cycles, starting 1 cycle after req.
  - Required: single m_req=3'b111 pulse. done exactly one cycle after the last busy falls, i.e. once ch1 drops.
- Sequential:
  - Stimulus: same stimulus, mode=1.
  - Required: m_req sequence 001, 010, 100. Each pulse occurs only after the previous channel's busy drops. cycles exceeds the parallel run by at least 7.
- Fill:
  - Stimulus: fill_en=1, DEPTH=16, FILL_BASE=1, mask=0.
  - Required: 16 consecutive writes with address 0..15 and din 1..16, then mem_we=0. done arrives 1 cycle later (LAUNCH→DONE). No m_req.
- Ignored start:
  - Stimulus: start asserted again mid-WAIT with a different mask.
  - Required: the run is unaffected, only the original channels are kicked, and one done pulse is produced.
- Reset mid-run:
  - Stimulus: reset during FILL at k=7.
  - Required: next cycle mem_we=0, mem_address=0, busy=0, no done pulse. A later start runs the full fill from k=0.
- Saturation:
  - Stimulus: CNT_W=4, one method busy for 40 cycles.
  - Required: cycles reads 15 at done.

Source files
------------

// File: rtl/go_dispatch.sv
// Launch controller: optional linear memory preload, then kicks method req/busy channels.
// Latency: start -> first m_req 1 cycle (no fill) or DEPTH+1 cycles (fill); done 1 cycle after last busy drop.
// Backpressure: none upstream; start is ignored while a run is in progress, methods gate progress via m_busy.
module go_dispatch #(
   parameter int     N_CH      = 3,
   parameter int     ADDR_W    = 32,
   parameter int     DATA_W    = 32,
   parameter longint DEPTH     = 16,
   parameter longint FILL_BASE = 1,
   parameter int     CNT_W     = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              fill_en,
   input  logic              mode,
   input  logic [N_CH-1:0]   en_mask,
   output logic [N_CH-1:0]   m_req,
   input  logic [N_CH-1:0]   m_busy,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_we,
   output logic              mem_oe,
   output logic [DATA_W-1:0] mem_din,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  cycles
);

   typedef enum logic [2:0] {IDLE, FILL, LAUNCH, WAIT, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t          state;
   logic            mode_q;
   logic [N_CH-1:0] pending;
   logic [N_CH-1:0] cur;
   logic [1:0]      settle;
   logic [N_CH-1:0] rest;
   logic            par_clear;
   logic            seq_clear;

   // Channels kicked on entry to LAUNCH: whole pending set, or only its lowest bit when sequential.
   function automatic logic [N_CH-1:0] kick_of(input logic seq, input logic [N_CH-1:0] p);
      return seq ? (p & (~p + N_CH'(1))) : p;
   endfunction

   // Memory ports are never read-disabled; only the write enable toggles.
   assign mem_oe = 1'b1;

   // Completion conditions evaluated once the settling window has elapsed.
   assign rest      = pending & ~cur;
   assign par_clear = ((m_busy & pending) == '0);
   assign seq_clear = ((m_busy & cur) == '0);

   // Run FSM with all outputs registered; m_req is set on entry to LAUNCH so it is high only there.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         mode_q      <= 1'b0;
         pending     <= '0;
         cur         <= '0;
         settle      <= '0;
         m_req       <= '0;
         mem_we      <= 1'b0;
         mem_address <= '0;
         mem_din     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         cycles      <= '0;
      end else begin
         m_req <= '0;
         done  <= 1'b0;
         if (busy && !(&cycles))
            cycles <= cycles + CNT_W'(1);
         case (state)
            IDLE: begin
               if (start) begin
                  mode_q  <= mode;
                  pending <= en_mask;
                  cycles  <= '0;
                  busy    <= 1'b1;
                  settle  <= '0;
                  if (fill_en) begin
                     state       <= FILL;
                     mem_we      <= 1'b1;
                     mem_address <= '0;
                     mem_din     <= DATA_W'(FILL_BASE);
                  end else begin
                     state <= LAUNCH;
                     m_req <= kick_of(mode, en_mask);
                     cur   <= kick_of(1'b1, en_mask);
                  end
               end
            end
            FILL: begin
               if (mem_address == LAST_ADDR) begin
                  mem_we      <= 1'b0;
                  mem_address <= '0;
                  mem_din     <= '0;
                  state       <= LAUNCH;
                  m_req       <= kick_of(mode_q, pending);
                  cur         <= kick_of(1'b1, pending);
               end else begin
                  mem_address <= mem_address + ADDR_W'(1);
                  mem_din     <= mem_din + DATA_W'(1);
               end
            end
            LAUNCH: begin
               settle <= '0;
               if (pending == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (settle != 2'd2) begin
                  settle <= settle + 2'd1;
               end else if (!mode_q) begin
                  if (par_clear) begin
                     state <= DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end
               end else if (seq_clear) begin
                  pending <= rest;
                  if (rest != '0) begin
                     state <= LAUNCH;
                     m_req <= kick_of(1'b1, rest);
                     cur   <= kick_of(1'b1, rest);
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_go_dispatch.sv
// Scoreboard bench for go_dispatch: expected req/write/done events queued per run, popped by a monitor.
// Latency: event times are hand-computed absolute cycle stamps relative to the accepted start.
// Backpressure: behavioural method models hold busy for a programmed number of cycles after each kick.
module tb_go_dispatch;

   typedef struct {
      int     kind;   // 0 = m_req pulse, 1 = memory write, 2 = done pulse
      longint a;
      longint b;
      longint at;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        fill_en = 1'b0;
   logic        mode = 1'b0;
   logic [2:0]  en_mask = '0;
   logic [2:0]  m_req;
   logic [2:0]  m_busy = '0;
   logic [31:0] mem_address;
   logic        mem_we;
   logic        mem_oe;
   logic [31:0] mem_din;
   logic        busy;
   logic        done;
   logic [31:0] cycles;

   logic        start2 = 1'b0;
   logic [0:0]  en_mask2 = 1'b1;
   logic [0:0]  m_req2;
   logic [0:0]  m_busy2 = 1'b0;
   logic [7:0]  mem_address2;
   logic        mem_we2;
   logic        mem_oe2;
   logic [7:0]  mem_din2;
   logic        busy2;
   logic        done2;
   logic [3:0]  cycles2;

   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   bit     mon_on = 1'b0;
   ev_t    q[$];
   int     lat[3];
   int     bcnt[3];
   bit     kick_d[3];

   go_dispatch dut (
      .clk(clk), .reset(reset), .start(start), .fill_en(fill_en), .mode(mode),
      .en_mask(en_mask), .m_req(m_req), .m_busy(m_busy), .mem_address(mem_address),
      .mem_we(mem_we), .mem_oe(mem_oe), .mem_din(mem_din), .busy(busy), .done(done),
      .cycles(cycles)
   );

   go_dispatch #(.N_CH(1), .ADDR_W(8), .DATA_W(8), .DEPTH(4), .FILL_BASE(1), .CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset), .start(start2), .fill_en(fill_en), .mode(mode),
      .en_mask(en_mask2), .m_req(m_req2), .m_busy(m_busy2), .mem_address(mem_address2),
      .mem_we(mem_we2), .mem_oe(mem_oe2), .mem_din(mem_din2), .busy(busy2), .done(done2),
      .cycles(cycles2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Method models: busy rises the cycle after a kick and stays high for lat[i] cycles.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 3; i++) begin
         if (bcnt[i] > 0) bcnt[i]--;
         if (kick_d[i]) bcnt[i] = lat[i];
         kick_d[i] = m_req[i];
         m_busy[i] = (bcnt[i] != 0);
      end
   end

   task automatic got(input int kind, input longint a, input longint b);
      ev_t e;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: kind=%0d a=%0h b=%0h at cyc=%0d, expected no event", kind, a, b, cyc);
      end else begin
         e = q.pop_front();
         if (e.kind != kind || e.a != a || e.b != b || (e.at >= 0 && e.at != cyc)) begin
            errors++;
            $display("FAIL event: got kind=%0d a=%0h b=%0h cyc=%0d, expected kind=%0d a=%0h b=%0h cyc=%0d",
                     kind, a, b, cyc, e.kind, e.a, e.b, e.at);
         end
      end
   endtask

   // Monitor: compares every observable DUT event against the head of the scoreboard.
   always @(negedge clk) begin
      if (mon_on) begin
         if (m_req != '0) got(0, longint'(m_req), 0);
         if (mem_we) got(1, longint'(mem_address), longint'(mem_din));
         if (done) begin
            got(2, longint'(cycles), 0);
            chk("busy_low_with_done", longint'(busy), 0);
         end
      end
   end

   task automatic push(input int kind, input longint a, input longint b, input longint at);
      ev_t e;
      e.kind = kind; e.a = a; e.b = b; e.at = at;
      q.push_back(e);
   endtask

   task automatic run_start(input logic f, input logic m, input logic [2:0] mask, output longint s);
      @(negedge clk);
      fill_en = f; mode = m; en_mask = mask; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      s = cyc;
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while (q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout: %0d events still pending, expected 0", name, q.size());
         q.delete();
      end
      repeat (4) @(posedge clk);
   endtask

   initial begin
      longint s;
      int     n;
      for (int i = 0; i < 3; i++) begin
         bcnt[i] = 0; kick_d[i] = 1'b0; lat[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_m_req", longint'(m_req), 0);
      chk("rst_mem_we", longint'(mem_we), 0);
      chk("rst_mem_oe", longint'(mem_oe), 1);
      chk("rst_mem_address", longint'(mem_address), 0);
      chk("rst_mem_din", longint'(mem_din), 0);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_cycles", longint'(cycles), 0);
      chk("rst_sat_cycles", longint'(cycles2), 0);
      mon_on = 1'b1;

      // Parallel launch, no fill: ch1 (9 cycles) is last to drop.
      lat[0] = 5; lat[1] = 9; lat[2] = 2;
      run_start(1'b0, 1'b0, 3'b111, s);
      push(0, 3'b111, 0, s);
      push(2, 11, 0, s + 11);
      drain("parallel", 60);

      // Sequential launch: each kick waits for the previous channel to drop.
      run_start(1'b0, 1'b1, 3'b111, s);
      push(0, 3'b001, 0, s);
      push(0, 3'b010, 0, s + 7);
      push(0, 3'b100, 0, s + 18);
      push(2, 22, 0, s + 22);
      drain("sequential", 80);

      // Start reissued mid-WAIT with another mask and mode must be ignored.
      run_start(1'b0, 1'b0, 3'b101, s);
      push(0, 3'b101, 0, s);
      push(2, 7, 0, s + 7);
      repeat (3) @(posedge clk);
      @(negedge clk);
      en_mask = 3'b010; mode = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      drain("ignored_start", 60);

      // Reset during the fill at k=7 aborts without a done pulse.
      run_start(1'b1, 1'b0, 3'b000, s);
      for (int k = 0; k < 8; k++) push(1, k, k + 1, s + k);
      repeat (7) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      chk("abort_mem_we", longint'(mem_we), 0);
      chk("abort_mem_address", longint'(mem_address), 0);
      chk("abort_busy", longint'(busy), 0);
      chk("abort_done", longint'(done), 0);
      chk("abort_cycles", longint'(cycles), 0);
      repeat (20) @(posedge clk);
      chk("abort_leftover_events", q.size(), 0);

      // Full fill from k=0, empty mask: LAUNCH goes straight to DONE.
      run_start(1'b1, 1'b0, 3'b000, s);
      for (int k = 0; k < 16; k++) push(1, k, k + 1, s + k);
      push(2, 17, 0, s + 17);
      repeat (16) @(posedge clk);
      #1;
      chk("post_fill_mem_we", longint'(mem_we), 0);
      chk("post_fill_mem_address", longint'(mem_address), 0);
      chk("post_fill_mem_din", longint'(mem_din), 0);
      drain("fill", 40);

      // Saturating 4-bit counter on a 40-cycle method.
      @(negedge clk);
      fill_en = 1'b0; mode = 1'b0; start2 = 1'b1;
      @(posedge clk);
      #1 start2 = 1'b0;
      chk("sat_m_req", longint'(m_req2), 1);
      @(posedge clk);
      #1 m_busy2 = 1'b1;
      repeat (40) @(posedge clk);
      #1 m_busy2 = 1'b0;
      n = 0;
      while (!done2 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!done2) begin
         errors++;
         $display("FAIL sat_done_timeout: done=0 after %0d cycles, expected 1", n);
      end
      chk("sat_cycles", longint'(cycles2), 15);

      repeat (5) @(posedge clk);
      chk("final_queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
